// File: rtl/cdb_arbiter_if.sv
// Handshake bundle between result producers, the CDB arbiter and
// the broadcast consumers (ROB / reservation stations).
interface cdb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3
);
  logic [2:0]          req_valid;
  logic [3*TAG_W-1:0]  req_tag;
  logic [3*DATA_W-1:0] req_data;
  logic [2:0]          req_ready;
  logic                cdb_stall;
  logic                flush;
  logic                cdb_valid;
  logic [TAG_W-1:0]    cdb_tag;
  logic [DATA_W-1:0]   cdb_data;
  logic [1:0]          cdb_src;

  modport master (
    output req_valid, req_tag, req_data,
    output cdb_stall, flush,
    input  req_ready,
    input  cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    input  req_valid, req_tag, req_data,
    input  cdb_stall, flush,
    output req_ready,
    output cdb_valid, cdb_tag, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Three-way common data bus arbiter with one registered broadcast slot.
// Define CDB_RR_EN for round-robin; default is fixed priority 0 > 1 > 2.
module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave bus
);

  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        src_q, src_d;

  logic       slot_free;
  logic       can_grant;
  logic       xfer;
  logic [2:0] gnt;
  logic [1:0] gidx;
  logic [1:0] o0, o1, o2;

  assign slot_free = !valid_q || !bus.cdb_stall;
  assign can_grant = slot_free && !bus.flush && !rst;

`ifdef CDB_RR_EN
  logic [1:0] ptr_q, ptr_d;

  // Search order rotates so the pointer index is tried first.
  assign o0 = ptr_q;
  assign o1 = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
  assign o2 = (ptr_q == 2'd0) ? 2'd2 : ptr_q - 2'd1;

  assign ptr_d = !xfer ? ptr_q :
                 (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 2'd0;
    else     ptr_q <= ptr_d;
  end
`else
  assign o0 = 2'd0;
  assign o1 = 2'd1;
  assign o2 = 2'd2;
`endif

  always_comb begin
    gnt  = 3'b000;
    gidx = o0;
    if (can_grant) begin
      if (bus.req_valid[o0]) begin
        gnt[o0] = 1'b1;
        gidx    = o0;
      end else if (bus.req_valid[o1]) begin
        gnt[o1] = 1'b1;
        gidx    = o1;
      end else if (bus.req_valid[o2]) begin
        gnt[o2] = 1'b1;
        gidx    = o2;
      end
    end
  end

  assign xfer = |gnt;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    src_d   = src_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (xfer) begin
      valid_d = 1'b1;
      tag_d   = bus.req_tag[int'(gidx)*TAG_W +: TAG_W];
      data_d  = bus.req_data[int'(gidx)*DATA_W +: DATA_W];
      src_d   = gidx;
    end else if (!bus.cdb_stall) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      src_q   <= 2'd0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.cdb_valid = valid_q;
  assign bus.cdb_tag   = tag_q;
  assign bus.cdb_data  = data_q;
  assign bus.cdb_src   = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: vector table plus reset and round-robin sequences.
// Expected grants are tabulated for both arbitration modes.
module tb_cdb_arbiter;
  localparam int DW = 32;
  localparam int TW = 3;
`ifdef CDB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.DATA_W(DW), .TAG_W(TW)) bus();
  cdb_arbiter #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [2:0] v;
    logic       st;
    logic       fl;
    logic [2:0] efx;
    logic [2:0] err;
  } vec_t;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic [1:0]    src;
  } bc_t;

  bc_t         sbq[$];
  bc_t         held;
  int unsigned cnt[3];
  int          tests;
  int          fails;
  logic        exp_v;
  vec_t        tbl[19];

  function automatic logic [TW-1:0] ptag(int i);
    return TW'((5 + 2 * i + cnt[i]) % 8);
  endfunction

  function automatic logic [DW-1:0] pdata(int i);
    return 32'hAA + DW'(i) * 32'h1000 + DW'(cnt[i]) * 32'h10_0000;
  endfunction

  task automatic drive_payload();
    for (int i = 0; i < 3; i++) begin
      bus.req_tag[i*TW +: TW]  = ptag(i);
      bus.req_data[i*DW +: DW] = pdata(i);
    end
  endtask

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [2:0] v, input logic st,
                      input logic fl, input logic [2:0] er);
    int gi;
    gi = -1;
    bus.req_valid = v;
    bus.cdb_stall = st;
    bus.flush     = fl;
    drive_payload();
    #3;
    check("req_ready", 64'(bus.req_ready), 64'(er));
    for (int i = 0; i < 3; i++)
      if (er[i] && v[i]) gi = i;
    if (gi >= 0)
      sbq.push_back('{ptag(gi), pdata(gi), 2'(gi)});
    if (fl)               exp_v = 1'b0;
    else if (gi >= 0)     exp_v = 1'b1;
    else if (!(exp_v && st)) exp_v = 1'b0;
    @(posedge clk);
    #1;
    check("cdb_valid", 64'(bus.cdb_valid), 64'(exp_v));
    if (gi >= 0) begin
      cnt[gi]++;
      held = sbq.pop_front();
    end
    if (exp_v) begin
      check("cdb_tag", 64'(bus.cdb_tag), 64'(held.tag));
      check("cdb_data", 64'(bus.cdb_data), 64'(held.data));
      check("cdb_src", 64'(bus.cdb_src), 64'(held.src));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tests = 0;
    fails = 0;
    exp_v = 1'b0;
    for (int i = 0; i < 3; i++) cnt[i] = 0;

    tbl[0]  = '{3'b001, 1'b0, 1'b0, 3'b001, 3'b001};
    tbl[1]  = '{3'b000, 1'b0, 1'b0, 3'b000, 3'b000};
    tbl[2]  = '{3'b111, 1'b0, 1'b0, 3'b001, 3'b010};
    tbl[3]  = '{3'b111, 1'b0, 1'b0, 3'b001, 3'b100};
    tbl[4]  = '{3'b111, 1'b0, 1'b0, 3'b001, 3'b001};
    tbl[5]  = '{3'b111, 1'b0, 1'b0, 3'b001, 3'b010};
    tbl[6]  = '{3'b111, 1'b0, 1'b0, 3'b001, 3'b100};
    tbl[7]  = '{3'b111, 1'b0, 1'b0, 3'b001, 3'b001};
    tbl[8]  = '{3'b110, 1'b1, 1'b0, 3'b000, 3'b000};
    tbl[9]  = '{3'b110, 1'b1, 1'b0, 3'b000, 3'b000};
    tbl[10] = '{3'b110, 1'b1, 1'b0, 3'b000, 3'b000};
    tbl[11] = '{3'b110, 1'b1, 1'b0, 3'b000, 3'b000};
    tbl[12] = '{3'b110, 1'b0, 1'b0, 3'b010, 3'b010};
    tbl[13] = '{3'b100, 1'b1, 1'b0, 3'b000, 3'b000};
    tbl[14] = '{3'b100, 1'b1, 1'b1, 3'b000, 3'b000};
    tbl[15] = '{3'b111, 1'b0, 1'b0, 3'b001, 3'b100};
    tbl[16] = '{3'b000, 1'b0, 1'b1, 3'b000, 3'b000};
    tbl[17] = '{3'b010, 1'b0, 1'b0, 3'b010, 3'b010};
    tbl[18] = '{3'b000, 1'b0, 1'b0, 3'b000, 3'b000};

    rst           = 1'b1;
    bus.req_valid = 3'b111;
    bus.cdb_stall = 1'b0;
    bus.flush     = 1'b0;
    drive_payload();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_valid", 64'(bus.cdb_valid), 64'd0);
    check("rst_tag", 64'(bus.cdb_tag), 64'd0);
    check("rst_data", 64'(bus.cdb_data), 64'd0);
    check("rst_src", 64'(bus.cdb_src), 64'd0);
    rst = 1'b0;

    for (int k = 0; k < 19; k++)
      step(tbl[k].v, tbl[k].st, tbl[k].fl, RR ? tbl[k].err : tbl[k].efx);

    // Reset while a broadcast is held under stall and all requesters wait.
    step(3'b111, 1'b0, 1'b0, RR ? 3'b100 : 3'b001);
    bus.cdb_stall = 1'b1;
    bus.req_valid = 3'b111;
    rst           = 1'b1;
    drive_payload();
    #3;
    check("midrst_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    check("midrst_valid", 64'(bus.cdb_valid), 64'd0);
    check("midrst_tag", 64'(bus.cdb_tag), 64'd0);
    check("midrst_data", 64'(bus.cdb_data), 64'd0);
    check("midrst_src", 64'(bus.cdb_src), 64'd0);
    exp_v = 1'b0;
    sbq.delete();
    rst = 1'b0;

    // Six back-to-back grants with every requester pending.
    step(3'b111, 1'b0, 1'b0, 3'b001);
    step(3'b111, 1'b0, 1'b0, RR ? 3'b010 : 3'b001);
    step(3'b111, 1'b0, 1'b0, RR ? 3'b100 : 3'b001);
    step(3'b111, 1'b0, 1'b0, 3'b001);
    step(3'b111, 1'b0, 1'b0, RR ? 3'b010 : 3'b001);
    step(3'b111, 1'b0, 1'b0, RR ? 3'b100 : 3'b001);
    step(3'b000, 1'b0, 1'b0, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
